// File: rtl/l1_bus_arbiter.sv
// rtl/l1_bus_arbiter.sv - two-cache L2 port arbiter with snoop cross-forwarding
// Write-backs beat reads, ties go round-robin, optional watchdog on l2_rdy.
module l1_bus_arbiter #(
    parameter int AW      = 24,
    parameter int DW      = 32,
    parameter int SW      = 3,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_ce,
    input  logic          req0_rw,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_rdy,
    output logic [DW-1:0] req0_rdata,
    input  logic [SW-1:0] req0_snoop_req,
    input  logic [AW-1:0] req0_sp_addr,
    output logic [SW-1:0] req0_snoop_sig,
    output logic [AW-1:0] req0_sp_addr_in,
    input  logic          req1_ce,
    input  logic          req1_rw,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_rdy,
    output logic [DW-1:0] req1_rdata,
    input  logic [SW-1:0] req1_snoop_req,
    input  logic [AW-1:0] req1_sp_addr,
    output logic [SW-1:0] req1_snoop_sig,
    output logic [AW-1:0] req1_sp_addr_in,
    output logic          l2_ce,
    output logic          l2_rw,
    output logic [AW-1:0] l2_addr,
    output logic [DW-1:0] l2_wdata,
    input  logic [DW-1:0] l2_rdata,
    input  logic          l2_rdy,
    output logic [1:0]    grant,
    output logic          err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last;
    logic [1:0]    r_grant;
    logic          r_rw;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_abort;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic [SW-1:0] r_snoop_sig0;
    logic [SW-1:0] r_snoop_sig1;
    logic [AW-1:0] r_sp_addr0;
    logic [AW-1:0] r_sp_addr1;

    logic w_any;
    logic w_win;
    logic w_wb0;
    logic w_wb1;
    logic w_timeout;

    assign w_any     = req0_ce | req1_ce;
    assign w_wb0     = req0_ce & ~req0_rw;
    assign w_wb1     = req1_ce & ~req1_rw;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    // w_win is the index of the winning cache: class first, then not-last.
    always_comb begin
        w_win = 1'b0;
        if (req0_ce && req1_ce) begin
            if (w_wb0 != w_wb1) w_win = w_wb1;
            else                w_win = ~r_last;
        end else begin
            w_win = req1_ce;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        l2_ce    = 1'b0;
        req0_rdy = 1'b0;
        req1_rdy = 1'b0;
        err      = 1'b0;
        grant    = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_next = S_GRANT;
            end
            S_GRANT: begin
                l2_ce = 1'b1;
                grant = r_grant;
                if (l2_rdy || w_timeout) w_next = S_RESP;
            end
            S_RESP: begin
                grant    = r_grant;
                req0_rdy = r_grant[0];
                req1_rdy = r_grant[1];
                err      = r_abort;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last       <= 1'b1;
            r_grant      <= 2'b00;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_abort      <= 1'b0;
            r_cnt        <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_snoop_sig0 <= '0;
            r_snoop_sig1 <= '0;
            r_sp_addr0   <= '0;
            r_sp_addr1   <= '0;
        end else begin
            r_snoop_sig0 <= req1_snoop_req;
            r_sp_addr0   <= req1_sp_addr;
            r_snoop_sig1 <= req0_snoop_req;
            r_sp_addr1   <= req0_sp_addr;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_rw    <= w_win ? req1_rw    : req0_rw;
                        r_addr  <= w_win ? req1_addr  : req0_addr;
                        r_wdata <= w_win ? req1_wdata : req0_wdata;
                        r_grant <= w_win ? 2'b10 : 2'b01;
                        r_last  <= w_win;
                        r_cnt   <= '0;
                        r_abort <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (l2_rdy) begin
                        if (r_rw && r_grant[0]) r_rdata0 <= l2_rdata;
                        if (r_rw && r_grant[1]) r_rdata1 <= l2_rdata;
                    end else if (w_timeout) begin
                        r_abort <= 1'b1;
                        if (r_grant[0]) r_rdata0 <= '0;
                        if (r_grant[1]) r_rdata1 <= '0;
                    end else if (r_cnt != {CW{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign l2_rw           = r_rw;
    assign l2_addr         = r_addr;
    assign l2_wdata        = r_wdata;
    assign req0_rdata      = r_rdata0;
    assign req1_rdata      = r_rdata1;
    assign req0_snoop_sig  = r_snoop_sig0;
    assign req1_snoop_sig  = r_snoop_sig1;
    assign req0_sp_addr_in = r_sp_addr0;
    assign req1_sp_addr_in = r_sp_addr1;

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// tb/tb_l1_bus_arbiter.sv - self-checking bench for l1_bus_arbiter
module tb_l1_bus_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int SW = 3;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_ce, req0_rw, req0_rdy;
    logic [AW-1:0] req0_addr, req0_sp_addr, req0_sp_addr_in;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic [SW-1:0] req0_snoop_req, req0_snoop_sig;
    logic          req1_ce, req1_rw, req1_rdy;
    logic [AW-1:0] req1_addr, req1_sp_addr, req1_sp_addr_in;
    logic [DW-1:0] req1_wdata, req1_rdata;
    logic [SW-1:0] req1_snoop_req, req1_snoop_sig;
    logic          l2_ce, l2_rw, l2_rdy, err;
    logic [AW-1:0] l2_addr;
    logic [DW-1:0] l2_wdata, l2_rdata;
    logic [1:0]    grant;

    l1_bus_arbiter #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_ce(req0_ce), .req0_rw(req0_rw), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_rdy(req0_rdy), .req0_rdata(req0_rdata),
        .req0_snoop_req(req0_snoop_req), .req0_sp_addr(req0_sp_addr),
        .req0_snoop_sig(req0_snoop_sig), .req0_sp_addr_in(req0_sp_addr_in),
        .req1_ce(req1_ce), .req1_rw(req1_rw), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_rdy(req1_rdy), .req1_rdata(req1_rdata),
        .req1_snoop_req(req1_snoop_req), .req1_sp_addr(req1_sp_addr),
        .req1_snoop_sig(req1_snoop_sig), .req1_sp_addr_in(req1_sp_addr_in),
        .l2_ce(l2_ce), .l2_rw(l2_rw), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_rdy(l2_rdy), .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_rd[2];
    int            model_last;

    typedef struct {
        logic          ce0;
        logic          rw0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          ce1;
        logic          rw1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        int            first;
        int            second;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int side, input logic ce, input logic rw,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (side == 0) begin
            req0_ce = ce; req0_rw = rw; req0_addr = a; req0_wdata = d;
        end else begin
            req1_ce = ce; req1_rw = rw; req1_addr = a; req1_wdata = d;
        end
    endtask

    // Arbitration rule: write-back beats read, equal class goes to the side not served last.
    function automatic int pick(input logic ce0, input logic rw0, input logic ce1,
                                input logic rw1, input int last);
        if (ce0 && ce1) begin
            if (rw0 != rw1) return rw0 ? 1 : 0;
            return (last == 1) ? 0 : 1;
        end
        return ce1 ? 1 : 0;
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        req0_ce = 0; req0_rw = 0; req0_addr = '0; req0_wdata = '0;
        req1_ce = 0; req1_rw = 0; req1_addr = '0; req1_wdata = '0;
        req0_snoop_req = '0; req0_sp_addr = '0; req1_snoop_req = '0; req1_sp_addr = '0;
        l2_rdy = 1'b0; l2_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        model_last = 1;
    endtask

    task automatic wait_ce(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (l2_ce) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_ce: l2_ce=0 after 20 cycles, required 1");
        end
    endtask

    // Called at a negedge inside GRANT; holds extra cycles, then completes with rd.
    task automatic finish_txn(input int side, input logic rw, input logic [AW-1:0] a,
                              input int extra, input logic [DW-1:0] rd);
        for (int i = 0; i < extra; i++) begin
            @(negedge clk);
            chk("l2_ce_hold", l2_ce, 1);
            chk("l2_addr_hold", l2_addr, a);
            if (side == 0) begin req0_addr = AW'($urandom); req0_wdata = $urandom; end
            else           begin req1_addr = AW'($urandom); req1_wdata = $urandom; end
        end
        l2_rdy = 1'b1;
        l2_rdata = rd;
        @(negedge clk);
        l2_rdy = 1'b0;
        l2_rdata = $urandom;
        if (rw) exp_rd[side] = rd;
        chk("l2_ce_resp", l2_ce, 0);
        chk("rdy_winner", side ? req1_rdy : req0_rdy, 1);
        chk("rdy_loser", side ? req0_rdy : req1_rdy, 0);
        chk("err_resp", err, 0);
        chk("rdata0", req0_rdata, exp_rd[0]);
        chk("rdata1", req1_rdata, exp_rd[1]);
        if (side == 0) req0_ce = 1'b0; else req1_ce = 1'b0;
        model_last = side;
    endtask

    task automatic do_txn(input int side, input logic rw, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int lat, input logic [DW-1:0] rd);
        bit ok;
        wait_ce(ok);
        if (!ok) return;
        chk("grant", grant, (side == 1) ? 2'b10 : 2'b01);
        chk("l2_rw", l2_rw, rw);
        chk("l2_addr", l2_addr, a);
        chk("l2_wdata", l2_wdata, d);
        finish_txn(side, rw, a, lat - 1, rd);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit            ok;
        int            cnt;
        logic [DW-1:0] rd;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic          c0, c1, w0, w1;
        int            w, o;

        apply_reset();
        chk("rst_l2_ce", l2_ce, 0);
        chk("rst_grant", grant, 0);
        chk("rst_err", err, 0);
        chk("rst_rdy", {req0_rdy, req1_rdy}, 0);
        chk("rst_rdata", {req0_rdata, req1_rdata}, 0);
        chk("rst_l2_bus", {l2_rw, l2_addr, l2_wdata}, 0);
        chk("rst_snoop", {req0_snoop_sig, req1_snoop_sig, req0_sp_addr_in, req1_sp_addr_in}, 0);

        // Single read with l2_rdy in the second GRANT cycle.
        set_req(0, 1, 1, 24'h245678, 32'h0);
        do_txn(0, 1, 24'h245678, 32'h0, 2, 32'h77889900);

        apply_reset();
        tbl[0] = '{1, 1, 24'h100000, 32'h0, 1, 1, 24'h200000, 32'h0, 0, 1};
        tbl[1] = '{1, 1, 24'h100000, 32'h0, 1, 1, 24'h200000, 32'h0, 0, 1};
        tbl[2] = '{1, 1, 24'hE73D47, 32'h0, 1, 0, 24'hD48000, 32'h2B2B2B2B, 1, 0};
        tbl[3] = '{1, 0, 24'h010101, 32'h11111111, 1, 0, 24'h020202, 32'h22222222, 1, 0};
        tbl[4] = '{1, 0, 24'h030303, 32'h33333333, 1, 1, 24'h040404, 32'h44444444, 0, 1};
        tbl[5] = '{0, 0, 24'h0, 32'h0, 1, 1, 24'h050505, 32'h55555555, 1, -1};
        tbl[6] = '{1, 1, 24'h060606, 32'h66666666, 0, 0, 24'h0, 32'h0, 0, -1};
        tbl[7] = '{1, 1, 24'h070707, 32'h77777777, 1, 1, 24'h080808, 32'h88888888, 1, 0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_req(0, tbl[i].ce0, tbl[i].rw0, tbl[i].a0, tbl[i].d0);
            set_req(1, tbl[i].ce1, tbl[i].rw1, tbl[i].a1, tbl[i].d1);
            rd = $urandom;
            if (tbl[i].first == 0) do_txn(0, tbl[i].rw0, tbl[i].a0, tbl[i].d0, 1, rd);
            else                   do_txn(1, tbl[i].rw1, tbl[i].a1, tbl[i].d1, 1, rd);
            rd = $urandom;
            if (tbl[i].second == 0)      do_txn(0, tbl[i].rw0, tbl[i].a0, tbl[i].d0, 1, rd);
            else if (tbl[i].second == 1) do_txn(1, tbl[i].rw1, tbl[i].a1, tbl[i].d1, 1, rd);
        end

        // Randomized request pairs against the arbitration model.
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            cnt = $urandom_range(1, 3);
            c0 = cnt[0]; c1 = cnt[1];
            w0 = 1'($urandom); w1 = 1'($urandom);
            a0 = AW'($urandom); a1 = AW'($urandom);
            d0 = $urandom; d1 = $urandom;
            set_req(0, c0, w0, a0, d0);
            set_req(1, c1, w1, a1, d1);
            w = pick(c0, w0, c1, w1, model_last);
            do_txn(w, w ? w1 : w0, w ? a1 : a0, w ? d1 : d0, $urandom_range(1, 5), $urandom);
            if (c0 && c1) begin
                o = 1 - w;
                do_txn(o, o ? w1 : w0, o ? a1 : a0, o ? d1 : d0, $urandom_range(1, 5), $urandom);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Snoop forwarding during a cache-1 GRANT.
        @(negedge clk);
        set_req(1, 1, 1, 24'h0ABCDE, 32'h0);
        wait_ce(ok);
        req0_snoop_req = 3'b010; req0_sp_addr = 24'h343520;
        @(negedge clk);
        req0_snoop_req = 3'b011; req0_sp_addr = 24'h111111;
        req1_snoop_req = 3'b101; req1_sp_addr = 24'h222222;
        chk("snoop1_sig", req1_snoop_sig, 3'b010);
        chk("snoop1_addr", req1_sp_addr_in, 24'h343520);
        chk("snoop0_idle", req0_snoop_sig, 0);
        chk("snoop_grant_ce", l2_ce, 1);
        chk("snoop_grant_addr", l2_addr, 24'h0ABCDE);
        @(negedge clk);
        req0_snoop_req = '0; req0_sp_addr = '0;
        req1_snoop_req = '0; req1_sp_addr = '0;
        chk("snoop_both_1", req1_snoop_sig, 3'b011);
        chk("snoop_both_0", req0_snoop_sig, 3'b101);
        chk("snoop_both_a0", req0_sp_addr_in, 24'h222222);
        chk("snoop_both_a1", req1_sp_addr_in, 24'h111111);
        @(negedge clk);
        chk("snoop_end", {req0_snoop_sig, req1_snoop_sig}, 0);
        chk("snoop_grant_ce2", l2_ce, 1);
        finish_txn(1, 1, 24'h0ABCDE, 0, 32'hCAFEF00D);

        // Watchdog abort with l2_rdy held low.
        @(negedge clk);
        set_req(1, 1, 1, 24'h0F0F0F, 32'h0);
        wait_ce(ok);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!l2_ce) break;
            cnt++;
        end
        chk("wd_cycles", cnt, TO);
        chk("wd_rdy1", req1_rdy, 1);
        chk("wd_rdy0", req0_rdy, 0);
        chk("wd_err", err, 1);
        chk("wd_rdata1", req1_rdata, 0);
        exp_rd[1] = '0;
        req1_ce = 1'b0;
        model_last = 1;
        @(negedge clk);
        chk("wd_err_clear", err, 0);
        set_req(1, 1, 1, 24'h0F0F10, 32'h0);
        do_txn(1, 1, 24'h0F0F10, 32'h0, 2, 32'h5A5A1234);

        // Reset in the third GRANT cycle, request still held.
        @(negedge clk);
        set_req(0, 1, 1, 24'h135790, 32'h0);
        wait_ce(ok);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        chk("rstmid_ce", l2_ce, 0);
        chk("rstmid_grant", grant, 0);
        chk("rstmid_rdy", {req0_rdy, req1_rdy}, 0);
        chk("rstmid_err", err, 0);
        @(negedge clk);
        chk("regrant_ce", l2_ce, 1);
        chk("regrant_grant", grant, 2'b01);
        chk("regrant_addr", l2_addr, 24'h135790);
        finish_txn(0, 1, 24'h135790, 0, 32'h0BADBEEF);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
